// File: rtl/nn_alu_sequencer.sv
// nn_alu_sequencer: control FSM for the neural-network ALU datapath.
// Processes one input sample per run through X-multiply, activation,
// Y-multiply and accumulate for every hidden neuron, then adds the offset.
//
// Ports:
//   CLK, reset (async, active low)
//   Start, LoadCoeff, InSample     : requests from the sample source
//   Busy, Result, ResultValid      : run status and final sum
//   ErrorFlag                      : sticky ALU error over the current run
//   InDato, Acumulador             : operands driven to the ALU
//   OutDato, Error                 : ALU sum output and error flag
//   Enable*, SELCoeffX/Y, SELOffset: ALU stage enables and selects
//
// Optional macro SEQ_ERROR_ABORT_EN: an ALU error in any active state
// abandons the run and returns to IDLE without a result.
module nn_alu_sequencer #(
    parameter int Width      = 32,
    parameter int NumNeurons = 10
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             Start,
    input  logic             LoadCoeff,
    input  logic [Width-1:0] InSample,
    output logic             Busy,
    output logic [Width-1:0] Result,
    output logic             ResultValid,
    output logic             ErrorFlag,
    output logic [Width-1:0] InDato,
    output logic [Width-1:0] Acumulador,
    input  logic [Width-1:0] OutDato,
    input  logic             Error,
    output logic             EnableLoadCoeff,
    output logic             EnableMulX,
    output logic             EnableRegOutMultCoeffX,
    output logic             EnableFuctAct,
    output logic             EnableRegActFunc,
    output logic             EnableMulY,
    output logic             EnableRegDesplazamiento,
    output logic             EnableSum,
    output logic [3:0]       SELCoeffX,
    output logic [3:0]       SELCoeffY,
    output logic             SELOffset
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULX,
        S_ACT,
        S_MULY,
        S_OFFSET
    } state_t;

    localparam logic [3:0] LastIdx = 4'(NumNeurons - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         idx;
    logic [3:0]         idx_nxt;
    logic [Width-1:0]   acc_nxt;
    logic [Width-1:0]   res_nxt;
    logic [Width-1:0]   indato_nxt;
    logic               rv_nxt;
    logic               err_nxt;
    logic               active;

    // States in which the ALU is doing work for the current sample.
    assign active = (state == S_MULX) || (state == S_ACT) ||
                    (state == S_MULY) || (state == S_OFFSET);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            Acumulador  <= '0;
            Result      <= '0;
            InDato      <= '0;
            ResultValid <= 1'b0;
            ErrorFlag   <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            Acumulador  <= acc_nxt;
            Result      <= res_nxt;
            InDato      <= indato_nxt;
            ResultValid <= rv_nxt;
            ErrorFlag   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        acc_nxt    = Acumulador;
        res_nxt    = Result;
        indato_nxt = InDato;
        rv_nxt     = 1'b0;
        err_nxt    = ErrorFlag;

        if (active && Error) begin
            err_nxt = 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                // Coefficient load wins; a coincident Start is dropped.
                if (LoadCoeff) begin
                    state_nxt = S_LOAD;
                end else if (Start) begin
                    state_nxt  = S_MULX;
                    indato_nxt = InSample;
                    acc_nxt    = '0;
                    idx_nxt    = '0;
                    err_nxt    = 1'b0;
                end
            end
            S_LOAD: begin
                state_nxt = S_IDLE;
            end
            S_MULX: begin
                state_nxt = S_ACT;
            end
            S_ACT: begin
                state_nxt = S_MULY;
            end
            S_MULY: begin
                // Close the accumulator loop with the ALU sum.
                acc_nxt = OutDato;
                if (idx == LastIdx) begin
                    state_nxt = S_OFFSET;
                end else begin
                    idx_nxt   = idx + 4'd1;
                    state_nxt = S_MULX;
                end
            end
            S_OFFSET: begin
                acc_nxt   = OutDato;
                res_nxt   = OutDato;
                rv_nxt    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

`ifdef SEQ_ERROR_ABORT_EN
        // Abandon the run: no accumulate, no result, no valid pulse.
        if (active && Error) begin
            state_nxt = S_IDLE;
            idx_nxt   = idx;
            acc_nxt   = Acumulador;
            res_nxt   = Result;
            rv_nxt    = 1'b0;
        end
`endif
    end

    // ALU controls depend only on the registered state and index.
    always_comb begin
        Busy                    = (state != S_IDLE);
        EnableLoadCoeff         = 1'b0;
        EnableMulX              = 1'b0;
        EnableRegOutMultCoeffX  = 1'b0;
        EnableFuctAct           = 1'b0;
        EnableRegActFunc        = 1'b0;
        EnableMulY              = 1'b0;
        EnableRegDesplazamiento = 1'b0;
        EnableSum               = 1'b0;
        SELCoeffX               = 4'd0;
        SELCoeffY               = 4'd0;
        SELOffset               = 1'b0;

        unique case (state)
            S_LOAD: begin
                EnableLoadCoeff = 1'b1;
            end
            S_MULX: begin
                SELCoeffX              = idx;
                EnableMulX             = 1'b1;
                EnableRegOutMultCoeffX = 1'b1;
            end
            S_ACT: begin
                EnableFuctAct    = 1'b1;
                EnableRegActFunc = 1'b1;
            end
            S_MULY: begin
                SELCoeffY               = idx;
                EnableMulY              = 1'b1;
                EnableRegDesplazamiento = 1'b1;
                EnableSum               = 1'b1;
            end
            S_OFFSET: begin
                EnableSum = 1'b1;
                SELOffset = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_nn_alu_sequencer.sv
// tb_nn_alu_sequencer: randomized self-checking bench for nn_alu_sequencer
// with a simple ALU stub and a cycle-count based reference model.
module tb_nn_alu_sequencer;

    localparam int W = 32;
    localparam int N = 10;

    logic          CLK = 1'b0;
    logic          reset;
    logic          Start;
    logic          LoadCoeff;
    logic [W-1:0]  InSample;
    logic          Busy;
    logic [W-1:0]  Result;
    logic          ResultValid;
    logic          ErrorFlag;
    logic [W-1:0]  InDato;
    logic [W-1:0]  Acumulador;
    logic [W-1:0]  OutDato;
    logic          Error;
    logic          EnableLoadCoeff;
    logic          EnableMulX;
    logic          EnableRegOutMultCoeffX;
    logic          EnableFuctAct;
    logic          EnableRegActFunc;
    logic          EnableMulY;
    logic          EnableRegDesplazamiento;
    logic          EnableSum;
    logic [3:0]    SELCoeffX;
    logic [3:0]    SELCoeffY;
    logic          SELOffset;

    nn_alu_sequencer #(.Width(W), .NumNeurons(N)) dut (
        .CLK(CLK),
        .reset(reset),
        .Start(Start),
        .LoadCoeff(LoadCoeff),
        .InSample(InSample),
        .Busy(Busy),
        .Result(Result),
        .ResultValid(ResultValid),
        .ErrorFlag(ErrorFlag),
        .InDato(InDato),
        .Acumulador(Acumulador),
        .OutDato(OutDato),
        .Error(Error),
        .EnableLoadCoeff(EnableLoadCoeff),
        .EnableMulX(EnableMulX),
        .EnableRegOutMultCoeffX(EnableRegOutMultCoeffX),
        .EnableFuctAct(EnableFuctAct),
        .EnableRegActFunc(EnableRegActFunc),
        .EnableMulY(EnableMulY),
        .EnableRegDesplazamiento(EnableRegDesplazamiento),
        .EnableSum(EnableSum),
        .SELCoeffX(SELCoeffX),
        .SELCoeffY(SELCoeffY),
        .SELOffset(SELOffset)
    );

    always #5 CLK = ~CLK;

    // ALU stub: Y products per neuron plus an offset.
    logic [W-1:0] yprod [16];
    logic [W-1:0] offset;

    always_comb begin
        if (EnableSum)
            OutDato = Acumulador + (SELOffset ? offset : yprod[SELCoeffY]);
        else
            OutDato = 32'hDEADBEEF;
    end

    // Model: t = cycles since accepted Start (0 = idle).
    int           t;
    bit           m_load;
    bit           m_rv;
    bit           m_err;
    logic [W-1:0] m_res;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_ind;

    int checks = 0;
    int failures = 0;
    int cyc_count = 0;

    int cnt_rv, cnt_desp, cnt_seloff, cnt_load, cnt_busy, cnt_mulx;
    int rv_cycle;
    logic [W-1:0] rv_result;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h",
                     name, cyc_count, act, exp);
        end
    endtask

    function automatic logic [17:0] dut_ctrl();
        return {Busy, EnableLoadCoeff, EnableMulX, EnableRegOutMultCoeffX,
                EnableFuctAct, EnableRegActFunc, EnableMulY,
                EnableRegDesplazamiento, EnableSum, SELCoeffX, SELCoeffY,
                SELOffset};
    endfunction

    function automatic logic [17:0] exp_ctrl();
        logic bz, le, mx, rx, fa, ra, my, rd, sm, so;
        logic [3:0] sx, sy;
        int k, s;
        bz = (t != 0) || m_load;
        le = m_load;
        {mx, rx, fa, ra, my, rd, sm, so} = '0;
        sx = 4'd0;
        sy = 4'd0;
        if (t >= 1 && t <= 3 * N) begin
            k = (t - 1) / 3;
            s = (t - 1) % 3;
            if (s == 0) begin
                mx = 1; rx = 1; sx = 4'(k);
            end else if (s == 1) begin
                fa = 1; ra = 1;
            end else begin
                my = 1; rd = 1; sm = 1; sy = 4'(k);
            end
        end else if (t == 3 * N + 1) begin
            sm = 1; so = 1;
        end
        return {bz, le, mx, rx, fa, ra, my, rd, sm, sx, sy, so};
    endfunction

    task automatic clr_counts();
        cnt_rv = 0; cnt_desp = 0; cnt_seloff = 0;
        cnt_load = 0; cnt_busy = 0; cnt_mulx = 0;
        rv_cycle = -1; rv_result = '0;
    endtask

    task automatic check_outputs();
        chk("ctrl", 64'(dut_ctrl()), 64'(exp_ctrl()));
        chk("result_valid", 64'(ResultValid), 64'(m_rv));
        chk("error_flag", 64'(ErrorFlag), 64'(m_err));
        chk("result", 64'(Result), 64'(m_res));
        chk("acumulador", 64'(Acumulador), 64'(m_acc));
        chk("in_dato", 64'(InDato), 64'(m_ind));
        if (ResultValid) begin
            cnt_rv++;
            rv_cycle = cyc_count;
            rv_result = Result;
        end
        if (EnableRegDesplazamiento) cnt_desp++;
        if (SELOffset) cnt_seloff++;
        if (EnableLoadCoeff) cnt_load++;
        if (Busy) cnt_busy++;
        if (EnableMulX) cnt_mulx++;
    endtask

    task automatic model_step(input bit s, input bit l, input bit e,
                              input logic [W-1:0] samp);
        bit abort;
        abort = 1'b0;
        m_rv = 1'b0;
        if (m_load) begin
            m_load = 1'b0;
        end else if (t == 0) begin
            if (l) begin
                m_load = 1'b1;
            end else if (s) begin
                t = 1; m_ind = samp; m_acc = '0; m_err = 1'b0;
            end
        end else begin
            if (e) m_err = 1'b1;
`ifdef SEQ_ERROR_ABORT_EN
            abort = e;
`endif
            if (abort) begin
                t = 0;
            end else if (t == 3 * N + 1) begin
                m_acc = m_acc + offset;
                m_res = m_acc;
                m_rv = 1'b1;
                t = 0;
            end else begin
                if ((t - 1) % 3 == 2) m_acc = m_acc + yprod[(t - 1) / 3];
                t++;
            end
        end
    endtask

    task automatic cyc(input bit s, input bit l, input bit e,
                       input logic [W-1:0] samp);
        check_outputs();
        Start = s; LoadCoeff = l; Error = e; InSample = samp;
        model_step(s, l, e, samp);
        @(posedge CLK);
        @(negedge CLK);
        cyc_count++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
    endtask

    task automatic do_reset();
        Start = 0; LoadCoeff = 0; Error = 0;
        reset = 1'b0;
        #1;
        chk("rst_ctrl", 64'(dut_ctrl()), 64'd0);
        chk("rst_rv", 64'(ResultValid), 64'd0);
        chk("rst_err", 64'(ErrorFlag), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_acc", 64'(Acumulador), 64'd0);
        chk("rst_indato", 64'(InDato), 64'd0);
        t = 0; m_load = 0; m_rv = 0; m_err = 0;
        m_res = '0; m_acc = '0; m_ind = '0;
        @(negedge CLK);
        reset = 1'b1;
        cyc_count++;
    endtask

    task automatic rand_alu();
        for (int i = 0; i < 16; i++) yprod[i] = $urandom;
        offset = $urandom;
    endtask

    initial begin
        int start_cycle;
        int i;
        reset = 1'b0; Start = 0; LoadCoeff = 0; Error = 0; InSample = '0;
        for (int j = 0; j < 16; j++) yprod[j] = 32'h00400000;
        offset = 32'h00200000;
        @(negedge CLK);
        do_reset();
        idle(2);

        // LoadCoeff with coincident Start
        clr_counts();
        cyc(1, 1, 0, 32'h12345678);
        idle(4);
        chk("load_pulses", 64'(cnt_load), 64'd1);
        chk("load_busy", 64'(cnt_busy), 64'd1);
        chk("load_no_mulx", 64'(cnt_mulx), 64'd0);

        // directed run: 10 * 1.0 + 0.5 = 10.5
        clr_counts();
        start_cycle = cyc_count;
        cyc(1, 0, 0, 32'h00100000);
        idle(33);
        chk("lat_cycles", 64'(rv_cycle - start_cycle), 64'd32);
        chk("dir_result", 64'(rv_result), 64'h02A00000);
        chk("model_result", 64'(m_res), 64'h02A00000);
        chk("desp_pulses", 64'(cnt_desp), 64'd10);
        chk("seloff_cycles", 64'(cnt_seloff), 64'd1);
        chk("rv_pulses", 64'(cnt_rv), 64'd1);

        // error during ACT of neuron 3
        clr_counts();
        cyc(1, 0, 0, 32'h00100000);
        for (i = 0; i < 20 && t != 11; i++) cyc(0, 0, 0, '0);
        chk("reach_act3", 64'(t), 64'd11);
        cyc(0, 0, 1, '0);
`ifdef SEQ_ERROR_ABORT_EN
        chk("abort_busy", 64'(Busy), 64'd0);
        idle(35);
        chk("abort_rv", 64'(cnt_rv), 64'd0);
        chk("abort_result", 64'(Result), 64'h02A00000);
`else
        idle(35);
        chk("err_rv", 64'(cnt_rv), 64'd1);
`endif
        chk("err_sticky", 64'(ErrorFlag), 64'd1);
        cyc(1, 0, 0, 32'h00100000);
        chk("err_cleared", 64'(ErrorFlag), 64'd0);
        idle(33);

        // ignored Start mid-run, then back-to-back Start
        clr_counts();
        cyc(1, 0, 0, 32'h00300000);
        idle(4);
        cyc(1, 0, 0, 32'h0BADF00D);
        for (i = 0; i < 40 && !m_rv; i++) cyc(0, 0, 0, '0);
        chk("rv_timeout", 64'(i < 40), 64'd1);
        cyc(1, 0, 0, 32'h00500000);
        chk("single_rv", 64'(cnt_rv), 64'd1);
        chk("b2b_mulx", 64'(EnableMulX), 64'd1);
        idle(33);

        // reset mid-run
        cyc(1, 0, 0, 32'h00700000);
        idle(10);
        do_reset();
        idle(2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (t == 0 && !m_load) rand_alu();
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 29) == 0, $urandom);
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
